// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with its controller FSM.
// Optional hit/miss counters are compiled in when CACHE_STATS_EN is defined.
module cache_ctrl_dm #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [WORD_W-1:0]            cpu_wdata,
    output logic [WORD_W-1:0]            cpu_rdata,
    output logic                         cpu_ready,
    input  logic                         flush,
    output logic                         mem_rd_req,
    output logic                         mem_wr_req,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]            mem_wdata,
    input  logic [LINE_WORDS*WORD_W-1:0] mem_line,
    input  logic                         mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                  stat_hits,
    output logic [31:0]                  stat_misses
`endif
);

    localparam int WSEL_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = LINE_WORDS * WORD_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  addr_tag;
    logic [WSEL_W-1:0] word_sel;
    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] data_mem [SETS];
    logic [LINE_W-1:0] line_rd;
    logic              hit;

    logic clear_valid;
    logic fill_line;
    logic write_word;

    // Byte-lane bits play no part: every access is a whole word.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^cpu_addr[1:0];

    assign idx      = cpu_addr[OFF_W +: IDX_W];
    assign addr_tag = cpu_addr[ADDR_W-1 -: TAG_W];
    assign word_sel = cpu_addr[2 +: WSEL_W];

    assign line_rd   = data_mem[idx];
    assign hit       = valid_q[idx] && (tag_mem[idx] == addr_tag);
    assign cpu_rdata = line_rd[word_sel*WORD_W +: WORD_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cpu_ready   = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        clear_valid = 1'b0;
        fill_line   = 1'b0;
        write_word  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    clear_valid = 1'b1;
                end else if (cpu_req) begin
                    if (cpu_we) begin
                        state_d = WRITE;
                    end else if (hit) begin
                        cpu_ready = 1'b1;
                    end else begin
                        state_d = REFILL;
                    end
                end
            end

            REFILL: begin
                mem_rd_req = 1'b1;
                mem_addr   = {cpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (mem_ack) begin
                    fill_line = 1'b1;
                    state_d   = IDLE;
                end
            end

            WRITE: begin
                mem_wr_req = 1'b1;
                mem_addr   = {cpu_addr[ADDR_W-1:2], 2'b00};
                mem_wdata  = cpu_wdata;
                if (mem_ack) begin
                    cpu_ready  = 1'b1;
                    write_word = hit;
                    state_d    = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with <=, so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (reset || clear_valid) begin
            valid_q <= '0;
        end else if (fill_line) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are not reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (fill_line) begin
            tag_mem[idx]  <= addr_tag;
            data_mem[idx] <= mem_line;
        end else if (write_word) begin
            data_mem[idx][word_sel*WORD_W +: WORD_W] <= cpu_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    logic read_hit;
    logic miss_start;
    logic after_refill_q;

    assign read_hit   = (state_q == IDLE) && !flush && cpu_req && !cpu_we && hit;
    assign miss_start = (state_q == IDLE) && !flush && cpu_req && !cpu_we && !hit;

    // The completion right after a refill belongs to the miss, so it is not counted as a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits      <= '0;
            stat_misses    <= '0;
            after_refill_q <= 1'b0;
        end else begin
            after_refill_q <= fill_line;
            if (read_hit && !after_refill_q) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (miss_start) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Directed bench for cache_ctrl_dm: a per-cycle vector table for the main scenarios,
// followed by hand-written sequences for reset mid-refill and the optional counters.
module tb_cache_ctrl_dm;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         flush;
    logic         mem_rd_req;
    logic         mem_wr_req;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_line;
    logic         mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0]  stat_hits;
    logic [31:0]  stat_misses;
`endif

    cache_ctrl_dm dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .flush      (flush),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_line   (mem_line),
        .mem_ack    (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0] D0 = 32'hA0A0_0000, D1 = 32'hA1A1_0001, D2 = 32'hA2A2_0002, D3 = 32'hA3A3_0003;
    localparam logic [31:0] E0 = 32'hB0B0_0000, E1 = 32'hB1B1_0001, E2 = 32'hB2B2_0002, E3 = 32'hB3B3_0003;
    localparam logic [31:0] C0 = 32'hC0C0_0000, C1 = 32'hC1C1_0001, C2 = 32'hC2C2_0002, C3 = 32'hC3C3_0003;
    localparam logic [127:0] LINE_A = {D3, D2, D1, D0};
    localparam logic [127:0] LINE_B = {E3, E2, E1, E0};
    localparam logic [127:0] LINE_C = {C3, C2, C1, C0};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One record per clock cycle: inputs held for the cycle, outputs expected before the edge.
    typedef struct {
        logic         req;
        logic         we;
        logic         flush;
        logic         ack;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        logic [127:0] line;
        logic         e_ready;
        logic         e_rd;
        logic         e_wr;
        logic [31:0]  e_rdata;
        logic [31:0]  e_maddr;
        logic [31:0]  e_mwdata;
    } vec_t;

    vec_t vecs[$];

    task automatic rd(input logic [31:0] addr, input logic ack, input logic [127:0] line,
                      input logic e_ready, input logic [31:0] e_rdata,
                      input logic e_rd, input logic [31:0] e_maddr);
        vec_t v = '{default: '0};
        v.req = 1'b1; v.addr = addr; v.ack = ack; v.line = line;
        v.e_ready = e_ready; v.e_rdata = e_rdata; v.e_rd = e_rd; v.e_maddr = e_maddr;
        vecs.push_back(v);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic ack,
                      input logic e_ready, input logic e_wr, input logic [31:0] e_maddr);
        vec_t v = '{default: '0};
        v.req = 1'b1; v.we = 1'b1; v.addr = addr; v.wdata = data; v.ack = ack;
        v.e_ready = e_ready; v.e_wr = e_wr; v.e_maddr = e_maddr; v.e_mwdata = data;
        vecs.push_back(v);
    endtask

    task automatic rd_flush(input logic [31:0] addr);
        vec_t v = '{default: '0};
        v.req = 1'b1; v.addr = addr; v.flush = 1'b1;
        vecs.push_back(v);
    endtask

    task automatic idle();
        vec_t v = '{default: '0};
        vecs.push_back(v);
    endtask

`ifdef CACHE_STATS_EN
    // Complete one access, acking any memory request at once; bounded to 8 cycles.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [127:0] line);
        logic done;
        done = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data; mem_line = line;
        for (int c = 0; c < 8 && !done; c++) begin
            if (c > 0) @(negedge clk);
            mem_ack = 1'b0;
            #1;
            mem_ack = mem_rd_req | mem_wr_req;
            #1;
            done = cpu_ready;
        end
        @(negedge clk);
        cpu_req = 1'b0; mem_ack = 1'b0;
        check($sformatf("access 0x%0h done", addr), {31'b0, done}, 32'd1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        flush = 1'b0; mem_line = '0; mem_ack = 1'b0;

        // miss then hit
        rd(32'h40,  1'b0, '0,     1'b0, '0, 1'b0, '0);
        rd(32'h40,  1'b0, '0,     1'b0, '0, 1'b1, 32'h40);
        rd(32'h40,  1'b1, LINE_A, 1'b0, '0, 1'b1, 32'h40);
        rd(32'h40,  1'b0, '0,     1'b1, D0, 1'b0, '0);
        rd(32'h4C,  1'b0, '0,     1'b1, D3, 1'b0, '0);
        rd(32'h4E,  1'b0, '0,     1'b1, D3, 1'b0, '0);
        rd(32'h48,  1'b0, '0,     1'b1, D2, 1'b0, '0);
        // conflict eviction at index 4
        rd(32'h240, 1'b0, '0,     1'b0, '0, 1'b0, '0);
        rd(32'h240, 1'b0, '0,     1'b0, '0, 1'b1, 32'h240);
        rd(32'h240, 1'b1, LINE_B, 1'b0, '0, 1'b1, 32'h240);
        rd(32'h240, 1'b0, '0,     1'b1, E0, 1'b0, '0);
        rd(32'h44,  1'b0, '0,     1'b0, '0, 1'b0, '0);
        rd(32'h44,  1'b0, '0,     1'b0, '0, 1'b1, 32'h40);
        rd(32'h44,  1'b1, LINE_A, 1'b0, '0, 1'b1, 32'h40);
        rd(32'h44,  1'b0, '0,     1'b1, D1, 1'b0, '0);
        // write hit updates the cached word
        wr(32'h44, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, '0);
        wr(32'h44, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h44);
        wr(32'h44, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 32'h44);
        idle();
        rd(32'h44,  1'b0, '0,     1'b1, 32'hDEADBEEF, 1'b0, '0);
        rd(32'h40,  1'b0, '0,     1'b1, D0, 1'b0, '0);
        // write miss: write-through only, byte-lane bits dropped
        wr(32'h83, 32'h1234_5678, 1'b0, 1'b0, 1'b0, '0);
        wr(32'h83, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h80);
        wr(32'h83, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 32'h80);
        idle();
        rd(32'h80,  1'b0, '0,     1'b0, '0, 1'b0, '0);
        rd(32'h80,  1'b0, '0,     1'b0, '0, 1'b1, 32'h80);
        rd(32'h80,  1'b1, LINE_C, 1'b0, '0, 1'b1, 32'h80);
        rd(32'h80,  1'b0, '0,     1'b1, C0, 1'b0, '0);
        // flush beats a hitting request, then both lines miss
        rd_flush(32'h80);
        rd(32'h80,  1'b0, '0,     1'b0, '0, 1'b0, '0);
        rd(32'h80,  1'b0, '0,     1'b0, '0, 1'b1, 32'h80);
        rd(32'h80,  1'b1, LINE_C, 1'b0, '0, 1'b1, 32'h80);
        rd(32'h84,  1'b0, '0,     1'b1, C1, 1'b0, '0);
        rd(32'h4C,  1'b0, '0,     1'b0, '0, 1'b0, '0);
        rd(32'h4C,  1'b0, '0,     1'b0, '0, 1'b1, 32'h40);
        rd(32'h4C,  1'b1, LINE_A, 1'b0, '0, 1'b1, 32'h40);
        rd(32'h4C,  1'b0, '0,     1'b1, D3, 1'b0, '0);
        idle();

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset cpu_ready",  {31'b0, cpu_ready},  32'd0);
        check("reset mem_rd_req", {31'b0, mem_rd_req}, 32'd0);
        check("reset mem_wr_req", {31'b0, mem_wr_req}, 32'd0);
        check("reset mem_addr",   mem_addr,  32'd0);
        check("reset mem_wdata",  mem_wdata, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cpu_req = vecs[i].req; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr;
            cpu_wdata = vecs[i].wdata; flush = vecs[i].flush;
            mem_ack = vecs[i].ack; mem_line = vecs[i].line;
            #1;
            check($sformatf("v%0d cpu_ready", i),  {31'b0, cpu_ready},  {31'b0, vecs[i].e_ready});
            check($sformatf("v%0d mem_rd_req", i), {31'b0, mem_rd_req}, {31'b0, vecs[i].e_rd});
            check($sformatf("v%0d mem_wr_req", i), {31'b0, mem_wr_req}, {31'b0, vecs[i].e_wr});
            if (vecs[i].e_ready && !vecs[i].we)
                check($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_rdata);
            if (vecs[i].e_rd || vecs[i].e_wr)
                check($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
            if (vecs[i].e_wr)
                check($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
        end

        // reset while a refill is outstanding; the ack lands one cycle after reset
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hC0; flush = 1'b0; mem_ack = 1'b0;
        #1;
        check("mid-rst lookup ready", {31'b0, cpu_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("mid-rst rd_req", {31'b0, mem_rd_req}, 32'd1);
        check("mid-rst mem_addr", mem_addr, 32'hC0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1; mem_line = LINE_B; cpu_req = 1'b0;
        #1;
        check("post-rst cpu_ready",  {31'b0, cpu_ready},  32'd0);
        check("post-rst mem_rd_req", {31'b0, mem_rd_req}, 32'd0);
        check("post-rst mem_wr_req", {31'b0, mem_wr_req}, 32'd0);
        check("post-rst mem_addr",   mem_addr,  32'd0);
        check("post-rst mem_wdata",  mem_wdata, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0; cpu_req = 1'b1; cpu_addr = 32'h40;
        #1;
        check("post-rst 0x40 misses", {31'b0, cpu_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("post-rst 0x40 rd_req", {31'b0, mem_rd_req}, 32'd1);
        check("post-rst 0x40 mem_addr", mem_addr, 32'h40);
        mem_ack = 1'b1; mem_line = LINE_A;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("post-rst 0x40 ready", {31'b0, cpu_ready}, 32'd1);
        check("post-rst 0x40 rdata", cpu_rdata, D0);
        @(negedge clk);
        cpu_addr = 32'hC0;
        #1;
        check("late ack not filled", {31'b0, cpu_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("0xC0 refill rd_req", {31'b0, mem_rd_req}, 32'd1);
        mem_ack = 1'b1; mem_line = LINE_C;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check("0xC0 refill rdata", cpu_rdata, C0);
        @(negedge clk);
        cpu_req = 1'b0;

`ifdef CACHE_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("stats after reset hits",   stat_hits,   32'd0);
        check("stats after reset misses", stat_misses, 32'd0);
        access(1'b0, 32'h40,  '0, LINE_A);
        access(1'b0, 32'h80,  '0, LINE_C);
        access(1'b0, 32'hC0,  '0, LINE_B);
        access(1'b0, 32'h40,  '0, '0);
        access(1'b0, 32'h44,  '0, '0);
        access(1'b0, 32'h80,  '0, '0);
        access(1'b0, 32'h84,  '0, '0);
        access(1'b0, 32'hC0,  '0, '0);
        access(1'b1, 32'h40,  32'h1, '0);
        access(1'b1, 32'h100, 32'h2, '0);
        #1;
        check("stat_hits",   stat_hits,   32'd5);
        check("stat_misses", stat_misses, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("stat_hits cleared",   stat_hits,   32'd0);
        check("stat_misses cleared", stat_misses, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
